polar_frame_sipo: RTL and testbench

Parametrised serial-to-parallel frame deserializer for the polar encoder datapath. It collects a serial bitstream into frames of a runtime-selectable length, up to `WIDTH` bits, and presents each frame as one parallel word. The output is double-buffered so a new frame can fill while the previous one waits. It sits between the serial message source and the polar encoder core, with valid/ready handshakes on both sides.

---
 rtl/polar_pkg.sv | 14 +
 rtl/polar_frame_sipo.sv | 150 +++++++++++++++
 tb/tb_polar_frame_sipo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/polar_pkg.sv
// Shared types and constants for the polar encoder datapath.
package polar_pkg;

    localparam int POLAR_N_MAX = 256;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } sipo_state_t;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/polar_frame_sipo.sv
// Serial-to-parallel frame deserializer with a double-buffered output word.
// Frame visible the cycle after its last bit; in_ready drops only while a completed frame waits for the holding register.
module polar_frame_sipo
    import polar_pkg::*;
#(
    parameter int WIDTH = POLAR_N_MAX,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_msb_first,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
    output logic [CNT_W-1:0] fill_level,
    output logic             cfg_err
);

    sipo_state_t      r_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] r_len;
    logic             r_msb;
    logic [WIDTH-1:0] r_hold_data;
    logic [CNT_W-1:0] r_hold_len;
    logic             r_out_valid;
    logic             r_cfg_err;

    logic             w_accept;
    logic             w_first;
    logic             w_cfg_bad;
    logic [CNT_W-1:0] w_cfg_len;
    logic [CNT_W-1:0] w_len;
    logic             w_msb;
    logic [CNT_W-1:0] w_fill_inc;
    logic [CNT_W-1:0] w_idx;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_done;
    logic             w_drain;

    // MSB-first always counts down from the latched length, even when in_last cuts the frame short.
    function automatic logic [CNT_W-1:0] bit_index(
        input logic             order,
        input logic [CNT_W-1:0] len,
        input logic [CNT_W-1:0] fill
    );
        if (order == ORDER_MSB)
            return len - fill - CNT_W'(1);
        else
            return fill;
    endfunction

    assign w_accept   = in_valid && r_in_ready;
    assign w_first    = (r_fill == '0);
    assign w_cfg_bad  = (cfg_len == '0) || (cfg_len > CNT_W'(WIDTH));
    assign w_cfg_len  = w_cfg_bad ? CNT_W'(WIDTH) : cfg_len;
    assign w_len      = w_first ? w_cfg_len : r_len;
    assign w_msb      = w_first ? cfg_msb_first : r_msb;
    assign w_fill_inc = r_fill + CNT_W'(1);
    assign w_idx      = bit_index(w_msb, w_len, r_fill);
    assign w_acc_base = w_first ? '0 : r_acc;
    assign w_done     = w_accept && ((w_fill_inc == w_len) || in_last);
    assign w_drain    = r_out_valid && out_ready;

    always_comb begin
        w_acc_next = w_acc_base;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_idx == CNT_W'(i))
                w_acc_next[i] = in_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
            r_acc       <= '0;
            r_fill      <= '0;
            r_len       <= '0;
            r_msb       <= ORDER_LSB;
            r_hold_data <= '0;
            r_hold_len  <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            // A reload below overrides this clear, giving back-to-back frames.
            if (w_drain)
                r_out_valid <= 1'b0;

            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_len <= w_len;
                            r_msb <= w_msb;
                            if (w_cfg_bad)
                                r_cfg_err <= 1'b1;
                        end
                        if (w_done && (!r_out_valid || out_ready)) begin
                            r_hold_data <= w_acc_next;
                            r_hold_len  <= w_fill_inc;
                            r_out_valid <= 1'b1;
                            r_fill      <= '0;
                            r_acc       <= '0;
                        end else begin
                            r_acc  <= w_acc_next;
                            r_fill <= w_fill_inc;
                            if (w_done) begin
                                r_state    <= WAIT;
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                end
                WAIT: begin
                    // r_fill holds the completed frame's length here.
                    if (w_drain) begin
                        r_hold_data <= r_acc;
                        r_hold_len  <= r_fill;
                        r_out_valid <= 1'b1;
                        r_fill      <= '0;
                        r_acc       <= '0;
                        r_state     <= FILL;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= FILL;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_hold_data;
    assign out_len    = r_hold_len;
    assign fill_level = r_fill;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_polar_frame_sipo.sv
// Directed bench for polar_frame_sipo (WIDTH=8) with a frame scoreboard and monitor.
module tb_polar_frame_sipo;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] cfg_len;
    logic             cfg_msb_first;
    logic             in_valid;
    logic             in_bit;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_len;
    logic [CNT_W-1:0] fill_level;
    logic             cfg_err;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [CNT_W-1:0] l;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    polar_frame_sipo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_len      (cfg_len),
        .cfg_msb_first(cfg_msb_first),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_len      (out_len),
        .fill_level   (fill_level),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshaken output frame is compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got frame 0x%0h len %0d, expected none", out_data, out_len);
            end else begin
                e = sb.pop_front();
                check("frame_data", 32'(out_data), 32'(e.d));
                check("frame_len", 32'(out_len), 32'(e.l));
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 50 cycles");
        end
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        @(posedge clk); #1;
    endtask

    task automatic send_stream(input logic [15:0] s, input int n, input int last_at);
        for (int k = 0; k < n; k++)
            send_bit(s[k], k == last_at);
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        reset         = 1'b1;
        cfg_len       = 4'd8;
        cfg_msb_first = 1'b0;
        in_valid      = 1'b0;
        in_bit        = 1'b0;
        in_last       = 1'b0;
        out_ready     = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Stream 1,0,1,1,0,0,1,0 (s[k] is the k-th bit), LSB-first.
        s = 16'h004D;
        push(8'h4D, 4'd8);
        send_stream(s, 7, -1);
        check("lat_before_last", 32'(out_valid), 32'd0);
        check("fill_7", 32'(fill_level), 32'd7);
        send_bit(s[7], 1'b0);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("fill_wrap", 32'(fill_level), 32'd0);
        idle(2);

        // Same stream, MSB-first.
        cfg_msb_first = 1'b1;
        push(8'hB2, 4'd8);
        send_stream(s, 8, -1);
        idle(2);

        // Length 5 with a stalled consumer: second frame parks in WAIT.
        cfg_msb_first = 1'b0;
        cfg_len       = 4'd5;
        out_ready     = 1'b0;
        s = 16'h0353;
        push(8'h13, 4'd5);
        push(8'h1A, 4'd5);
        send_stream(s, 5, -1);
        check("f1_valid", 32'(out_valid), 32'd1);
        check("f1_in_ready", 32'(in_ready), 32'd1);
        for (int k = 5; k < 10; k++)
            send_bit(s[k], 1'b0);
        check("wait_in_ready", 32'(in_ready), 32'd0);
        check("wait_fill", 32'(fill_level), 32'd5);
        check("wait_hold_stable", 32'(out_data), 32'h13);
        @(posedge clk); #1;
        check("wait_ignore_fill", 32'(fill_level), 32'd5);
        check("wait_ignore_rdy", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("reload_valid", 32'(out_valid), 32'd1);
        check("reload_data", 32'(out_data), 32'h1A);
        check("reload_in_ready", 32'(in_ready), 32'd1);
        check("reload_fill", 32'(fill_level), 32'd0);
        @(posedge clk); #1;
        check("drained_valid", 32'(out_valid), 32'd0);
        idle(1);

        // Early termination with in_last on the third bit.
        cfg_len = 4'd8;
        push(8'h07, 4'd3);
        send_stream(16'h0007, 3, 2);
        check("early_fill", 32'(fill_level), 32'd0);
        check("early_len", 32'(out_len), 32'd3);
        idle(2);
        cfg_msb_first = 1'b1;
        push(8'hE0, 4'd3);
        send_stream(16'h0007, 3, 2);
        idle(2);

        // Illegal lengths clamp to WIDTH and set the sticky error.
        cfg_msb_first = 1'b0;
        cfg_len       = 4'd0;
        push(8'h4D, 4'd8);
        send_stream(16'h004D, 8, -1);
        check("cfg_err_len0", 32'(cfg_err), 32'd1);
        idle(2);
        cfg_len = 4'd9;
        push(8'hFF, 4'd8);
        send_stream(16'h00FF, 8, -1);
        idle(2);
        cfg_len = 4'd8;
        push(8'h01, 4'd8);
        send_stream(16'h0001, 8, -1);
        idle(2);
        check("cfg_err_sticky", 32'(cfg_err), 32'd1);

        // Asynchronous reset with a held frame and a partial frame in flight.
        out_ready = 1'b0;
        push(8'h4D, 4'd8);
        send_stream(16'h004D, 8, -1);
        send_stream(16'h000F, 4, -1);
        idle(0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_fill", 32'(fill_level), 32'd4);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_len", 32'(out_len), 32'd0);
        check("arst_fill", 32'(fill_level), 32'd0);
        check("arst_cfg_err", 32'(cfg_err), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        push(8'h82, 4'd8);
        send_stream(16'h0082, 8, -1);
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
